sva_until_monitor: RTL

- Synthesizable runtime monitor for the SVA until-family operators: `until`, `s_until`, `until_with` and `s_until_with`.
- Each `start` pulse opens one obligation "a OP b", evaluated from that same cycle onward.
- The block resolves all open obligations and reports pass/fail counts, so the operator semantics can be checked in hardware.
- Intended as the design-under-check beside property regressions: a formal bench asserts its outputs against the equivalent SVA properties.

---
 rtl/sva_until_if.sv | 26 ++
 rtl/sva_until_monitor.sv | 115 +++++++++++
 2 files changed

// File: rtl/sva_until_if.sv
// Stimulus and result bundle for the until-family operator monitor.
interface sva_until_if #(
    parameter int unsigned CNT_W = 4
) ();
    logic             start;
    logic             a;
    logic             b;
    logic             eot;
    logic             pass;
    logic             fail;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] pending;
    logic             ended;
    logic             overflow;

    modport master (
        output start, a, b, eot,
        input  pass, fail, pass_cnt, fail_cnt, pending, ended, overflow
    );

    modport slave (
        input  start, a, b, eot,
        output pass, fail, pass_cnt, fail_cnt, pending, ended, overflow
    );
endinterface

// File: rtl/sva_until_monitor.sv
// Runtime monitor for until / s_until / until_with / s_until_with obligations.
// All open obligations see the same future inputs, so they are tracked as a
// single count and resolve together.
module sva_until_monitor #(
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sva_until_if.slave  bus
);
    localparam int unsigned LIVE_W  = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit OP_WITH   = (MODE >= 2);
    localparam bit OP_STRONG = (MODE == 1) || (MODE == 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ENDED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             pass_q, fail_q;
    logic             overflow_q, overflow_d;

    logic              pass_cond_c;
    logic              fail_cond_c;
    logic              res_pass_c;
    logic              res_fail_c;
    logic [LIVE_W-1:0] live_c;
    logic [CNT_W-1:0]  live_sat_c;

    // Operator verdict for this cycle's inputs, shared by every live obligation.
    always_comb begin
        pass_cond_c = OP_WITH ? (bus.a & bus.b) : bus.b;
        fail_cond_c = ~pass_cond_c & ~bus.a;
        res_pass_c  = pass_cond_c | (~pass_cond_c & ~fail_cond_c & bus.eot & ~OP_STRONG);
        res_fail_c  = fail_cond_c | (~pass_cond_c & ~fail_cond_c & bus.eot & OP_STRONG);
        live_c      = LIVE_W'(pending_q) + LIVE_W'(bus.start);
        live_sat_c  = (live_c > LIVE_W'(CNT_MAX)) ? CNT_MAX : live_c[CNT_W-1:0];
    end

    // Next-state, pending count and resolution counts.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pass_cnt_d = '0;
        fail_cnt_d = '0;
        overflow_d = overflow_q;
        case (state_q)
            IDLE, WAIT: begin
                if (live_c != '0) begin
                    if (res_pass_c || res_fail_c) begin
                        pass_cnt_d = res_pass_c ? live_sat_c : '0;
                        fail_cnt_d = res_fail_c ? live_sat_c : '0;
                        pending_d  = '0;
                        if (live_c > LIVE_W'(CNT_MAX)) begin
                            overflow_d = 1'b1;
                        end
                    end else if (bus.start && (pending_q == CNT_MAX)) begin
                        overflow_d = 1'b1;
                    end else begin
                        pending_d = live_c[CNT_W-1:0];
                    end
                end
                if (bus.eot) begin
                    state_d   = ENDED;
                    pending_d = '0;
                end else begin
                    state_d = (pending_d != '0) ? WAIT : IDLE;
                end
            end
            ENDED: begin
                pending_d = '0;
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State and output registers; reset discards open obligations silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            pass_q     <= (pass_cnt_d != '0);
            fail_q     <= (fail_cnt_d != '0);
            overflow_q <= overflow_d;
        end
    end

    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.pending  = pending_q;
    assign bus.ended    = (state_q == ENDED);
    assign bus.overflow = overflow_q;
endmodule
